// File: rtl/shift_pkg.sv
// shift_pkg: shared mode and controller state types for the shift register slice.
package shift_pkg;
  typedef enum logic [2:0] {
    M_HOLD,
    M_SHR,
    M_SHL,
    M_LOAD,
    M_ROR,
    M_ROL,
    M_ASR,
    M_RSVD
  } shift_mode_t;
  typedef enum logic {
    S_IDLE,
    S_SEND
  } shift_state_t;
endpackage

// File: rtl/shift_reg_ctrl_if.sv
// shift_reg_ctrl_if: parallel/serial data and transmit handshake bundle.
interface shift_reg_ctrl_if #(parameter int WIDTH = 8);
  logic             sl;
  logic             sr;
  logic [WIDTH-1:0] par_in;
  logic [2:0]       m;
  logic             start;
  logic [WIDTH-1:0] par_out;
  logic             ser_out;
  logic             busy;
  logic             done;
  modport master(output sl, sr, par_in, m, start, input par_out, ser_out, busy, done);
  modport slave(input sl, sr, par_in, m, start, output par_out, ser_out, busy, done);
endinterface

// File: rtl/shift_core.sv
// shift_core: WIDTH-bit register with the universal shift/rotate/load mode mux.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  shift_mode_t      mode,
  input  logic             sl,
  input  logic             sr,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d;
  always_comb begin
    d = q;
    case (mode)
      M_SHR:   d = {sl, q[WIDTH-1:1]};
      M_SHL:   d = {q[WIDTH-2:0], sr};
      M_LOAD:  d = par_in;
      M_ROR:   d = {q[0], q[WIDTH-1:1]};
      M_ROL:   d = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:   d = {q[WIDTH-1], q[WIDTH-1:1]};
      default: d = q;
    endcase
  end
  always_ff @(negedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: universal shift register plus LSB-first serial transmit controller.
module shift_reg_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  shift_reg_ctrl_if.slave  bus
);
  shift_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done, done_n;
  shift_mode_t      mode;
  logic [WIDTH-1:0] q;
  // During a transmit the datapath is forced to load on start, then shift right.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    mode    = shift_mode_t'(bus.m);
    if (state == S_IDLE) begin
      if (bus.start) begin
        state_n = S_SEND;
        cnt_n   = CNT_W'(WIDTH - 1);
        mode    = M_LOAD;
      end
    end else begin
      mode    = M_SHR;
      state_n = (cnt == '0) ? S_IDLE : S_SEND;
      done_n  = (cnt == '0);
      cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
    end
  end
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .sl    (bus.sl),
    .sr    (bus.sr),
    .par_in(bus.par_in),
    .q     (q)
  );
  assign bus.par_out = q;
  assign bus.ser_out = q[0];
  assign bus.busy    = (state == S_SEND);
  assign bus.done    = done;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: directed vectors for modes, transmit, priority, back-to-back and abort.
module tb_shift_reg_ctrl;
  logic clk = 1'b1;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  shift_reg_ctrl_if #(.WIDTH(8)) bus ();
  shift_reg_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic do_mode(input string tag, input logic [2:0] mode, input logic [7:0] exp);
    bus.m = 3'd3;
    bus.par_in = 8'hB4;
    tick();
    bus.m = mode;
    tick();
    bus.m = 3'd0;
    check(tag, 32'(bus.par_out), 32'(exp));
  endtask
  // Entered in busy cycle 1; leaves in the done cycle.
  task automatic stream(input string tag, input logic [7:0] word, input logic fill);
    logic [7:0] w;
    w = word;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_ser"}, 32'(bus.ser_out), 32'(w[i]));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_final"}, 32'(bus.par_out), 32'({8{fill}}));
  endtask
  initial begin
    bus.sl = 1'b0;
    bus.sr = 1'b0;
    bus.par_in = 8'h00;
    bus.m = 3'd0;
    bus.start = 1'b0;
    tick();
    tick();
    check("rst_par", 32'(bus.par_out), 32'h00);
    check("rst_ser", 32'(bus.ser_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();
    bus.sl = 1'b1;
    do_mode("shr", 3'd1, 8'hDA);
    bus.sr = 1'b1;
    do_mode("shl", 3'd2, 8'h69);
    do_mode("ror", 3'd4, 8'h5A);
    do_mode("rol", 3'd5, 8'h69);
    do_mode("asr", 3'd6, 8'hDA);
    do_mode("rsvd", 3'd7, 8'hB4);
    do_mode("hold", 3'd0, 8'hB4);
    // asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    check("async_par", 32'(bus.par_out), 32'h00);
    check("async_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    bus.sl = 1'b0;
    bus.par_in = 8'hA5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    stream("tx", 8'hA5, 1'b0);
    tick();
    check("tx_done_once", 32'(bus.done), 32'd0);
    bus.m = 3'd2;
    bus.sr = 1'b1;
    bus.par_in = 8'h81;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.m = 3'd0;
    check("prio_load", 32'(bus.par_out), 32'h81);
    check("prio_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    bus.start = 1'b1;
    bus.par_in = 8'hFF;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ign_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    check("ign_busy8", 32'(bus.busy), 32'd1);
    tick();
    check("ign_done", 32'(bus.done), 32'd1);
    tick();
    check("ign_done_once", 32'(bus.done), 32'd0);
    check("ign_noqueue", 32'(bus.busy), 32'd0);
    bus.par_in = 8'h5A;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    stream("b2b1", 8'h5A, 1'b0);
    bus.par_in = 8'h3C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    stream("b2b2", 8'h3C, 1'b0);
    tick();
    bus.par_in = 8'hC3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_bit4", 32'(bus.ser_out), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_par", 32'(bus.par_out), 32'h00);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    check("abort_done_held", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_nodone", 32'(bus.done), 32'd0);
    bus.sl = 1'b1;
    bus.par_in = 8'h96;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    stream("post", 8'h96, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
